// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: handshake bundle between the requesters / uart_tx side and the arbiter.
//   req       requester valid bits, one per requester
//   req_data  packed bytes, requester i in [i*DATA_LEN +: DATA_LEN]
//   ack       one-cycle "byte taken" pulse, one-hot
//   tx_data   byte presented to uart_tx
//   tx_start  one-cycle load strobe to uart_tx
//   tx_empty  uart_tx idle flag (1 = idle)
// master: the system side (requesters plus uart_tx); slave: the arbiter.
interface uart_tx_arb_if #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DATA_LEN = 8
);
    logic [N_REQ-1:0]          req;
    logic [N_REQ*DATA_LEN-1:0] req_data;
    logic [N_REQ-1:0]          ack;
    logic [DATA_LEN-1:0]       tx_data;
    logic                      tx_start;
    logic                      tx_empty;

    modport master (
        output req, req_data, tx_empty,
        input  ack, tx_data, tx_start
    );

    modport slave (
        input  req, req_data, tx_empty,
        output ack, tx_data, tx_start
    );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart_tx between N_REQ byte requesters.
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bus        uart_tx_arb_if.slave (req/req_data/ack and tx_data/tx_start/tx_empty)
//   owner      index of the last granted requester
//   busy       high whenever the arbiter is not idle
//   tmo_err    sticky: uart_tx did not go busy within START_TMO cycles of a start
//   frame_cnt  completed frames, wrapping 16-bit counter
module uart_tx_arb #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_LEN  = 8,
    parameter int unsigned START_TMO = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_tx_arb_if.slave             bus,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic                     tmo_err,
    output logic [15:0]              frame_cnt
);
    localparam int unsigned OW = $clog2(N_REQ);
    localparam int unsigned TW = $clog2(START_TMO + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StWaitBusy, StWaitEmpty} state_e;

    state_e              state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [DATA_LEN-1:0] tx_data_q, tx_data_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                tmo_err_q, tmo_err_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic [OW-1:0]       win;
    logic [OW-1:0]       cand;

    // Round-robin pick: walk offsets from farthest to nearest so the nearest
    // asserted request after owner_q is the one left in win.
    always_comb begin
        win  = owner_q;
        cand = owner_q;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = OW'((int'(owner_q) + k) % N_REQ);
            if (bus.req[cand]) win = cand;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= OW'(N_REQ - 1);
            tx_data_q   <= '0;
            ack_q       <= '0;
            tmo_cnt_q   <= '0;
            tmo_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            tx_data_q   <= tx_data_d;
            ack_q       <= ack_d;
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_err_q   <= tmo_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        tx_data_d   = tx_data_q;
        ack_d       = '0;
        tmo_cnt_d   = tmo_cnt_q;
        tmo_err_d   = tmo_err_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            StIdle: begin
                if ((|bus.req) && bus.tx_empty) begin
                    state_d     = StLoad;
                    owner_d     = win;
                    tx_data_d   = bus.req_data[win*DATA_LEN +: DATA_LEN];
                    ack_d[win]  = 1'b1;
                end
            end
            StLoad: begin
                state_d   = StWaitBusy;
                tmo_cnt_d = '0;
            end
            StWaitBusy: begin
                if (!bus.tx_empty) begin
                    state_d = StWaitEmpty;
                end else if (tmo_cnt_q == TW'(START_TMO - 1)) begin
                    // Still idle on the last allowed cycle: give up on this frame.
                    tmo_err_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StWaitEmpty: begin
                if (bus.tx_empty) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        bus.tx_start = (state_q == StLoad);
        busy         = (state_q != StIdle);
        bus.ack      = ack_q;
        bus.tx_data  = tx_data_q;
        owner        = owner_q;
        tmo_err      = tmo_err_q;
        frame_cnt    = frame_cnt_q;
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;
    localparam int N   = 4;
    localparam int D   = 8;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  owner;
    logic        busy;
    logic        tmo_err;
    logic [15:0] frame_cnt;

    uart_tx_arb_if #(.N_REQ(N), .DATA_LEN(D)) bus_if ();

    uart_tx_arb #(
        .N_REQ    (N),
        .DATA_LEN (D),
        .START_TMO(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .owner    (owner),
        .busy     (busy),
        .tmo_err  (tmo_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;

    // Reference model state
    int          owner_m;
    logic [15:0] frame_m;
    logic        tmo_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Winner = first set bit of the mask rotated so that position 0 is last+1.
    function automatic int rr_model(input int last, input logic [N-1:0] mask);
        logic [2*N-1:0] dbl;
        int             start;
        start = (last + 1) % N;
        dbl   = {mask, mask} >> start;
        for (int p = 0; p < N; p++) begin
            if (dbl[p]) return (start + p) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        owner_m = N - 1;
        frame_m = 16'h0000;
        tmo_m   = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus_if.req    = '0;
        bus_if.tx_empty = 1'b1;
        step();
        check("rst_busy", busy, 0);
        check("rst_owner", owner, N - 1);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_tmo_err", tmo_err, 0);
        check("rst_ack", bus_if.ack, 0);
        check("rst_tx_start", bus_if.tx_start, 0);
        check("rst_tx_data", bus_if.tx_data, 0);
        rst = 1'b0;
        model_reset();
    endtask

    // One full frame: grant, LOAD, uart goes busy after dly cycles for len cycles, then idle.
    task automatic run_frame(input logic [N-1:0] mask, input logic [N*D-1:0] data,
                             input bit hold, input int dly, input int len, output int winner);
        logic [D-1:0] exp_byte;
        winner   = rr_model(owner_m, mask);
        exp_byte = data[winner*D +: D];
        bus_if.req      = mask;
        bus_if.req_data = data;
        bus_if.tx_empty = 1'b1;
        step();
        check("load_ack", bus_if.ack, 32'd1 << winner);
        check("load_tx_data", bus_if.tx_data, exp_byte);
        check("load_tx_start", bus_if.tx_start, 1);
        check("load_owner", owner, winner);
        check("load_busy", busy, 1);
        owner_m = winner;
        if (!hold) bus_if.req = '0;
        step();
        check("wb_ack", bus_if.ack, 0);
        check("wb_tx_start", bus_if.tx_start, 0);
        repeat (dly) step();
        bus_if.tx_empty = 1'b0;
        repeat (len) step();
        bus_if.tx_empty = 1'b1;
        step();
        frame_m = frame_m + 16'd1;
        check("done_frame_cnt", frame_cnt, frame_m);
        check("done_busy", busy, 0);
        check("done_tmo_err", tmo_err, tmo_m);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst             = 1'b1;
        bus_if.req      = '0;
        bus_if.req_data = '0;
        bus_if.tx_empty = 1'b1;
        @(negedge clk);
        do_reset();

        // Single request
        run_frame(4'b0001, 32'h0000_006C, 1'b0, 1, 3, w);
        check("single_winner", w, 0);
        check("single_frames", frame_cnt, 1);

        // Round-robin with all requests held
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_frame(4'b1111, 32'hA3A2_A1A0, 1'b1, 0, 2, w);
            check("rr_order", w, i % N);
        end
        bus_if.req = '0;
        check("rr_frames", frame_cnt, 5);

        // Fairness after skip: get owner=1, then 1001 -> 3 then 0
        run_frame(4'b0010, $urandom, 1'b0, 0, 1, w);
        check("skip_owner1", owner, 1);
        run_frame(4'b1001, $urandom, 1'b0, 2, 2, w);
        check("skip_first", w, 3);
        run_frame(4'b1001, $urandom, 1'b0, 0, 4, w);
        check("skip_second", w, 0);

        // Blocked start while uart_tx busy
        bus_if.tx_empty = 1'b0;
        bus_if.req      = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            check("blocked_ack", bus_if.ack, 0);
            check("blocked_busy", busy, 0);
        end
        run_frame(4'b0010, $urandom, 1'b0, 0, 1, w);
        check("blocked_winner", w, 1);

        // Timeout: uart_tx never leaves idle
        bus_if.req      = 4'b0100;
        bus_if.req_data = $urandom;
        step();
        check("tmo_ack", bus_if.ack, 4'b0100);
        owner_m    = 2;
        bus_if.req = '0;
        step();
        for (int i = 0; i < TMO; i++) begin
            check("tmo_early", tmo_err, 0);
            check("tmo_busy", busy, 1);
            step();
        end
        tmo_m = 1'b1;
        check("tmo_set", tmo_err, 1);
        check("tmo_idle", busy, 0);
        check("tmo_frames", frame_cnt, frame_m);
        run_frame(4'b1000, $urandom, 1'b0, 1, 1, w);
        check("tmo_served", w, 3);

        // Reset mid-frame in WAIT_EMPTY
        bus_if.req = 4'b0001;
        step();
        bus_if.req = '0;
        step();
        bus_if.tx_empty = 1'b0;
        step();
        step();
        check("mid_busy_pre", busy, 1);
        do_reset();

        // Wrap of frame_cnt
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        frame_m = 16'hFFFF;
        run_frame(4'b0100, $urandom, 1'b0, 0, 1, w);
        check("wrap", frame_cnt, 0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] m;
            m = N'($urandom_range(0, 15));
            if (m == '0) begin
                bus_if.req = '0;
                step();
                check("rnd_noreq_ack", bus_if.ack, 0);
                check("rnd_noreq_busy", busy, 0);
            end else begin
                run_frame(m, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                          $urandom_range(1, 5), w);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
